light_countdown: RTL and testbench
==================================

LIGHT_COUNTDOWN -- requirements
Module: light_countdown

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning Clk cycles per display digit slot (minimum 2).
REQ-002 SHALL have parameter G_TIME, default 55, meaning green duration in seconds.
REQ-003 SHALL have parameter Y_TIME, default 5, meaning yellow duration in seconds; G_TIME+Y_TIME SHALL be at most 99.
REQ-004 SHALL have port Clk, input, 1, the single clock.
REQ-005 SHALL have port Rst, input, 1, reset; one clock; reset is synchronous and active-high.
REQ-006 SHALL have port en, input, 1, display enable.
REQ-007 SHALL have port tick_1s, input, 1, one-Clk pulse per second, shared with the light controller.
REQ-008 SHALL have ports R1, R2, Y1, Y2, G1, G2, input, 1 each, light vector from the light controller (light 1 = NS, light 2 = EW).
REQ-009 SHALL have port cnt1_bcd, output, 8, light-1 seconds remaining in its current colour, as two BCD digits {tens, ones}.
REQ-010 SHALL have port cnt2_bcd, output, 8, light-2 seconds remaining in its current colour, same format as cnt1_bcd.
REQ-011 SHALL have port an, output, 4, one-hot digit select, active-high.
REQ-012 SHALL have port seg, output, 7, segments {g..a}, active-low.
REQ-013 SHALL have port phase_err, output, 1, flag for an illegal light vector.

Function
REQ-014 Valid vectors {R1,R2,Y1,Y2,G1,G2} SHALL be: R1R2=110000, R1G2=100001, R1Y2=100100, G1R2=010010, Y1R2=011000.
REQ-015 Block SHALL register the light vector each cycle (prev_vec); a change is cur != prev_vec.
REQ-016 On a change to R1G2: cnt1 <= G_TIME+Y_TIME and cnt2 <= G_TIME.
REQ-017 On a change to R1Y2: cnt2 <= Y_TIME; cnt1 is unchanged.
REQ-018 On a change to G1R2: cnt1 <= G_TIME and cnt2 <= G_TIME+Y_TIME.
REQ-019 On a change to Y1R2: cnt1 <= Y_TIME; cnt2 is unchanged.
REQ-020 On a change to R1R2: both counters <= 0.
REQ-021 With no change and tick_1s=1, each nonzero counter SHALL decrement by 1 in BCD (ones 0 → 9 with a tens borrow); a counter at 00 SHALL hold at 00.
REQ-022 If a change and tick_1s occur in the same cycle, the load SHALL win and no decrement SHALL occur.
REQ-023 Counter latency: cnt*_bcd SHALL update on the Clk edge after the change or tick is sampled (1 cycle).
REQ-024 If the vector is not in REQ-014: phase_err=1 (registered, 1 cycle), both counters <= 0, and an=0000; phase_err SHALL clear on the first cycle after a valid vector returns.
REQ-025 en=0 SHALL force both counters to 0, an=0000 and seg=1111111; prev_vec SHALL keep tracking, so re-enable does not load until the next change.
REQ-026 Scan: a prescaler SHALL count 0..SCAN_DIV-1 and wrap; at each wrap the digit index 0..3 SHALL advance and wrap 3 → 0.
REQ-027 Digit mapping SHALL be: index 0 = cnt1 tens on an=0001; index 1 = cnt1 ones on an=0010; index 2 = cnt2 tens on an=0100; index 3 = cnt2 ones on an=1000.
REQ-028 an and seg SHALL be registered and change together, one cycle after the index changes.
REQ-029 A BCD digit >9 SHALL decode to all segments off.

Reset
REQ-030 On Rst=1 at a Clk edge: cnt1_bcd=00, cnt2_bcd=00, an=0000, seg=1111111, phase_err=0, prescaler=0, index=0, prev_vec=110000.
REQ-031 Rst mid-countdown SHALL take priority over every other input in the same cycle.
REQ-032 After Rst releases with the lights at R1G2, the first cycle SHALL be treated as a change, loading per REQ-016.

Structure
REQ-033 Shared package light_pkg SHALL hold the five 6-bit light encodings, the G_TIME/Y_TIME defaults and the BCD digit type.
REQ-034 Combinational sub-module bcd7seg (4-bit BCD in, 7-bit active-low segments out) SHALL be instantiated once on the muxed digit.

Verification
REQ-035 Reset, then vector R1G2: cnt1=60, cnt2=55; after 55 ticks cnt2=00, cnt1=05.
REQ-036 R1G2 → R1Y2 change: cnt2=05, cnt1 continues (05 → 00 over 5 ticks); G1R2: cnt1=55, cnt2=60.
REQ-037 tick_1s and change to Y1R2 in the same cycle: cnt1=05 with no decrement; BCD borrow check: 10 → 09 on one tick.
REQ-038 Vector 111111: phase_err=1 next cycle, counters 00, an=0000; restore G1R2: err clears and cnt1=55.
REQ-039 SCAN_DIV=4, cnt1=60, cnt2=55: an walks 0001,0010,0100,1000 every 4 cycles; seg reads 6,0,5,5 (0000010, 1000000, 0010010, 0010010).
REQ-040 en=0 mid-countdown: an=0000, seg=1111111, counters 00; en=1 with no change: counters stay 00 until the next change.

Source files
------------

// File: rtl/light_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : light_pkg
//  Description : Shared definitions for the traffic-light countdown display:
//                the legal light-vector encodings, default phase durations,
//                the BCD digit types and small BCD helper functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package light_pkg;

    // Light vector bit order is {R1, R2, Y1, Y2, G1, G2}
    // (light 1 = north/south, light 2 = east/west).
    localparam logic [5:0] c_vec_r1r2 = 6'b110000;
    localparam logic [5:0] c_vec_r1g2 = 6'b100001;
    localparam logic [5:0] c_vec_r1y2 = 6'b100100;
    localparam logic [5:0] c_vec_g1r2 = 6'b010010;
    localparam logic [5:0] c_vec_y1r2 = 6'b011000;

    // Default phase durations in seconds. Their sum must fit in two BCD digits.
    localparam int c_g_time_def = 55;
    localparam int c_y_time_def = 5;

    // One BCD digit, and a two-digit BCD value laid out as {tens, ones}.
    typedef logic [3:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t tens;
        bcd_digit_t ones;
    } bcd2_t;

    // Binary seconds (0..99) to two BCD digits; used for load constants.
    function automatic bcd2_t to_bcd2(input int v);
        bcd2_t r;
        r.tens = bcd_digit_t'((v / 10) % 10);
        r.ones = bcd_digit_t'(v % 10);
        return r;
    endfunction

    // Decrement by one second in BCD; 00 saturates rather than wrapping.
    function automatic bcd2_t bcd2_dec(input bcd2_t v);
        bcd2_t r;
        r = v;
        if (v.ones != 4'd0) begin
            r.ones = v.ones - 4'd1;
        end else if (v.tens != 4'd0) begin
            r.ones = 4'd9;
            r.tens = v.tens - 4'd1;
        end
        return r;
    endfunction

    // True only for the five vectors the light controller may legally emit.
    function automatic logic vec_is_legal(input logic [5:0] v);
        logic ok;
        case (v)
            c_vec_r1r2,
            c_vec_r1g2,
            c_vec_r1y2,
            c_vec_g1r2,
            c_vec_y1r2: ok = 1'b1;
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/light_countdown_bcd7seg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd7seg
//  Description : Combinational BCD-to-seven-segment decoder. Output bit order
//                is {g,f,e,d,c,b,a}, active-low. Codes above 9 blank the
//                digit so a corrupted value never shows a misleading glyph.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd7seg
    import light_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    // Segment lookup; anything outside 0..9 turns every segment off.
    always_comb begin
        o_seg = 7'b1111111;
        case (bcd_digit_t'(i_digit))
            4'd0:    o_seg = 7'b1000000;
            4'd1:    o_seg = 7'b1111001;
            4'd2:    o_seg = 7'b0100100;
            4'd3:    o_seg = 7'b0110000;
            4'd4:    o_seg = 7'b0011001;
            4'd5:    o_seg = 7'b0010010;
            4'd6:    o_seg = 7'b0000010;
            4'd7:    o_seg = 7'b1111000;
            4'd8:    o_seg = 7'b0000000;
            4'd9:    o_seg = 7'b0010000;
            default: o_seg = 7'b1111111;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/light_countdown.sv
`default_nettype none
// ============================================================================
//  Module      : light_countdown
//  Description : Per-direction "seconds remaining" countdown for a two-way
//                traffic light. Watches the light vector from the controller,
//                reloads a BCD counter for each direction whenever the vector
//                changes, decrements on the shared 1 s tick, flags illegal
//                vectors and multiplexes the four digits onto a single
//                seven-segment display.
//                G_TIME + Y_TIME must not exceed 99; SCAN_DIV must be >= 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module light_countdown
    import light_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int G_TIME   = c_g_time_def,
    parameter int Y_TIME   = c_y_time_def
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       en,
    input  logic       tick_1s,
    input  logic       R1,
    input  logic       R2,
    input  logic       Y1,
    input  logic       Y2,
    input  logic       G1,
    input  logic       G2,
    output logic [7:0] cnt1_bcd,
    output logic [7:0] cnt2_bcd,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       phase_err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                     c_presc_w   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_presc_w-1:0]   c_presc_max = c_presc_w'(SCAN_DIV - 1);

    // Load values: the direction that is red waits through the other side's
    // green plus yellow, so it loads the sum.
    localparam bcd2_t c_ld_g  = to_bcd2(G_TIME);
    localparam bcd2_t c_ld_y  = to_bcd2(Y_TIME);
    localparam bcd2_t c_ld_gy = to_bcd2(G_TIME + Y_TIME);

    localparam logic [6:0] c_seg_blank = 7'b1111111;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [5:0]           w_cur_vec;
    logic                 w_legal;
    logic                 w_change;
    logic [5:0]           r_prev_vec;

    bcd2_t                r_cnt1;
    bcd2_t                r_cnt2;
    bcd2_t                w_cnt1_nxt;
    bcd2_t                w_cnt2_nxt;

    logic [c_presc_w-1:0] r_presc;
    logic [1:0]           r_idx;
    bcd_digit_t           w_digit;
    logic [6:0]           w_seg_dec;

    logic [3:0]           r_an;
    logic [6:0]           r_seg;
    logic                 r_phase_err;

    // ------------------------------------------------------------------------
    // Light vector classification
    // ------------------------------------------------------------------------
    assign w_cur_vec = {R1, R2, Y1, Y2, G1, G2};
    assign w_legal   = vec_is_legal(w_cur_vec);
    assign w_change  = (w_cur_vec != r_prev_vec);

    // Previous-vector tracker; keeps following the lights even while the
    // display is disabled so that re-enabling does not look like a change.
    // Reset value is all-red so lights already at R1G2 load on release.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_prev_vec <= c_vec_r1r2;
        end else begin
            r_prev_vec <= w_cur_vec;
        end
    end

    // ------------------------------------------------------------------------
    // Countdown next-state: disable/illegal clear > change load > tick
    // ------------------------------------------------------------------------
    // Next counter values; a load on a change always beats a same-cycle tick.
    always_comb begin
        w_cnt1_nxt = r_cnt1;
        w_cnt2_nxt = r_cnt2;
        if (!en || !w_legal) begin
            w_cnt1_nxt = '0;
            w_cnt2_nxt = '0;
        end else if (w_change) begin
            case (w_cur_vec)
                c_vec_r1g2: begin
                    w_cnt1_nxt = c_ld_gy;
                    w_cnt2_nxt = c_ld_g;
                end
                c_vec_r1y2: begin
                    w_cnt2_nxt = c_ld_y;
                end
                c_vec_g1r2: begin
                    w_cnt1_nxt = c_ld_g;
                    w_cnt2_nxt = c_ld_gy;
                end
                c_vec_y1r2: begin
                    w_cnt1_nxt = c_ld_y;
                end
                c_vec_r1r2: begin
                    w_cnt1_nxt = '0;
                    w_cnt2_nxt = '0;
                end
                default: begin
                    w_cnt1_nxt = '0;
                    w_cnt2_nxt = '0;
                end
            endcase
        end else if (tick_1s) begin
            w_cnt1_nxt = bcd2_dec(r_cnt1);
            w_cnt2_nxt = bcd2_dec(r_cnt2);
        end
    end

    // Countdown registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_cnt1 <= '0;
            r_cnt2 <= '0;
        end else begin
            r_cnt1 <= w_cnt1_nxt;
            r_cnt2 <= w_cnt2_nxt;
        end
    end

    // Illegal-vector flag, one cycle behind the vector it describes.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_phase_err <= 1'b0;
        end else begin
            r_phase_err <= ~w_legal;
        end
    end

    // ------------------------------------------------------------------------
    // Display scanning
    // ------------------------------------------------------------------------
    // Prescaler and digit index; the index steps once per prescaler wrap.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_presc <= '0;
            r_idx   <= 2'd0;
        end else if (r_presc == c_presc_max) begin
            r_presc <= '0;
            r_idx   <= r_idx + 2'd1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Digit select: NS tens, NS ones, EW tens, EW ones, left to right.
    always_comb begin
        w_digit = r_cnt1.tens;
        case (r_idx)
            2'd0:    w_digit = r_cnt1.tens;
            2'd1:    w_digit = r_cnt1.ones;
            2'd2:    w_digit = r_cnt2.tens;
            2'd3:    w_digit = r_cnt2.ones;
            default: w_digit = r_cnt1.tens;
        endcase
    end

    bcd7seg u_bcd7seg (
        .i_digit (w_digit),
        .o_seg   (w_seg_dec)
    );

    // Anode and segment registers move together so no digit ever shows
    // another digit's pattern; disabled or illegal states turn anodes off.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_an  <= 4'b0000;
            r_seg <= c_seg_blank;
        end else if (!en) begin
            r_an  <= 4'b0000;
            r_seg <= c_seg_blank;
        end else if (!w_legal) begin
            r_an  <= 4'b0000;
            r_seg <= w_seg_dec;
        end else begin
            r_an  <= 4'b0001 << r_idx;
            r_seg <= w_seg_dec;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign cnt1_bcd  = r_cnt1;
    assign cnt2_bcd  = r_cnt2;
    assign an        = r_an;
    assign seg       = r_seg;
    assign phase_err = r_phase_err;

endmodule
`default_nettype wire

// File: tb/tb_light_countdown.sv
`default_nettype none
// ============================================================================
//  Module      : tb_light_countdown
//  Description : Directed scoreboard bench for light_countdown. Stimulus
//                pushes hand-computed expectations tagged with the cycle they
//                fall due; a monitor pops and compares on falling edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_light_countdown;
    import light_pkg::*;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       en;
    logic       tick_1s;
    logic       R1, R2, Y1, Y2, G1, G2;
    logic [7:0] cnt1_bcd;
    logic [7:0] cnt2_bcd;
    logic [3:0] an;
    logic [6:0] seg;
    logic       phase_err;

    light_countdown #(
        .SCAN_DIV (4),
        .G_TIME   (55),
        .Y_TIME   (5)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .en        (en),
        .tick_1s   (tick_1s),
        .R1        (R1),
        .R2        (R2),
        .Y1        (Y1),
        .Y2        (Y2),
        .G1        (G1),
        .G2        (G2),
        .cnt1_bcd  (cnt1_bcd),
        .cnt2_bcd  (cnt2_bcd),
        .an        (an),
        .seg       (seg),
        .phase_err (phase_err)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    localparam logic [3:0] M_CNT = 4'b0001;
    localparam logic [3:0] M_ERR = 4'b0010;
    localparam logic [3:0] M_AN  = 4'b0100;
    localparam logic [3:0] M_SEG = 4'b1000;

    typedef struct packed {
        int         due;
        logic [3:0] mask;
        logic [7:0] c1;
        logic [7:0] c2;
        logic       err;
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    exp_t  sb[$];
    string sb_name[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic push_exp(input int dly, input string nm, input logic [3:0] mask,
                            input logic [7:0] c1, input logic [7:0] c2, input logic err,
                            input logic [3:0] an_e, input logic [6:0] seg_e);
        exp_t e;
        e.due  = cyc + dly;
        e.mask = mask;
        e.c1   = c1;
        e.c2   = c2;
        e.err  = err;
        e.an   = an_e;
        e.seg  = seg_e;
        sb.push_back(e);
        sb_name.push_back(nm);
    endtask

    task automatic exp_cnt(input int dly, input string nm, input logic [7:0] c1, input logic [7:0] c2);
        push_exp(dly, nm, M_CNT | M_ERR, c1, c2, 1'b0, 4'b0000, 7'b1111111);
    endtask

    task automatic exp_scan(input int dly, input string nm, input logic [3:0] an_e, input logic [6:0] seg_e);
        push_exp(dly, nm, M_AN | M_SEG, 8'h00, 8'h00, 1'b0, an_e, seg_e);
    endtask

    task automatic cmp(input string nm, input string fld, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s @cyc %0d: got %h, expected %h", nm, fld, cyc, act, req);
        end
    endtask

    // Monitor: compare every expectation that has fallen due.
    exp_t  m_e;
    string m_nm;
    always @(negedge Clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            m_e  = sb.pop_front();
            m_nm = sb_name.pop_front();
            if (m_e.mask[0]) begin
                cmp(m_nm, "cnt1", cnt1_bcd, m_e.c1);
                cmp(m_nm, "cnt2", cnt2_bcd, m_e.c2);
            end
            if (m_e.mask[1]) cmp(m_nm, "phase_err", {7'b0, phase_err}, {7'b0, m_e.err});
            if (m_e.mask[2]) cmp(m_nm, "an", {4'b0, an}, {4'b0, m_e.an});
            if (m_e.mask[3]) cmp(m_nm, "seg", {1'b0, seg}, {1'b0, m_e.seg});
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic set_vec(input logic [5:0] v);
        {R1, R2, Y1, Y2, G1, G2} = v;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;

        // Reset with lights already at R1G2.
        Rst = 1'b1; en = 1'b1; tick_1s = 1'b0;
        set_vec(c_vec_r1g2);
        push_exp(1, "reset", M_CNT | M_ERR | M_AN | M_SEG, 8'h00, 8'h00, 1'b0, 4'b0000, 7'b1111111);
        step(2);

        // Release: first cycle is a change to R1G2, then scan walks digits 6,0,5,5.
        Rst = 1'b0;
        exp_cnt(1, "release_load", 8'h60, 8'h55);
        exp_scan(2,  "scan_d0", 4'b0001, 7'b0000010);
        exp_scan(5,  "scan_d1", 4'b0010, 7'b1000000);
        exp_scan(9,  "scan_d2", 4'b0100, 7'b0010010);
        exp_scan(13, "scan_d3", 4'b1000, 7'b0010010);
        exp_scan(17, "scan_wrap", 4'b0001, 7'b0000010);
        step(17);

        // 55 ticks of R1G2 green, including the 10 -> 09 borrow on cnt1.
        tick_1s = 1'b1;
        exp_cnt(1,  "tick1",    8'h59, 8'h54);
        exp_cnt(50, "tick50",   8'h10, 8'h05);
        exp_cnt(51, "borrow",   8'h09, 8'h04);
        exp_cnt(55, "green_end",8'h05, 8'h00);
        step(55);
        tick_1s = 1'b0;

        // R1Y2: cnt2 loads yellow, cnt1 keeps running and both hold at 00.
        set_vec(c_vec_r1y2);
        exp_cnt(1, "r1y2_load", 8'h05, 8'h05);
        step(1);
        tick_1s = 1'b1;
        exp_cnt(1, "yellow_t1", 8'h04, 8'h04);
        exp_cnt(5, "yellow_end", 8'h00, 8'h00);
        exp_cnt(7, "hold_zero", 8'h00, 8'h00);
        step(7);
        tick_1s = 1'b0;

        // G1R2, then Y1R2 arriving together with a tick.
        set_vec(c_vec_g1r2);
        exp_cnt(1, "g1r2_load", 8'h55, 8'h60);
        step(1);
        tick_1s = 1'b1;
        exp_cnt(50, "g1r2_t50", 8'h05, 8'h10);
        step(50);
        set_vec(c_vec_y1r2);
        exp_cnt(1, "load_beats_tick", 8'h05, 8'h10);
        step(1);
        exp_cnt(1, "y1r2_borrow", 8'h04, 8'h09);
        step(1);
        tick_1s = 1'b0;

        // Illegal vector, then recovery to G1R2.
        set_vec(6'b111111);
        push_exp(1, "illegal", M_CNT | M_ERR | M_AN, 8'h00, 8'h00, 1'b1, 4'b0000, 7'b1111111);
        push_exp(2, "illegal_hold", M_CNT | M_ERR | M_AN, 8'h00, 8'h00, 1'b1, 4'b0000, 7'b1111111);
        step(2);
        set_vec(c_vec_g1r2);
        exp_cnt(1, "recover", 8'h55, 8'h60);
        step(1);

        // Reset wins over a same-cycle change and tick.
        Rst = 1'b1; tick_1s = 1'b1;
        set_vec(c_vec_r1g2);
        push_exp(1, "rst_priority", M_CNT | M_ERR | M_AN | M_SEG, 8'h00, 8'h00, 1'b0, 4'b0000, 7'b1111111);
        step(1);
        Rst = 1'b0; tick_1s = 1'b0;
        exp_cnt(1, "rst_release", 8'h60, 8'h55);
        step(1);

        // Display disable mid-countdown, re-enable without a change.
        tick_1s = 1'b1;
        exp_cnt(3, "pre_disable", 8'h57, 8'h52);
        step(3);
        en = 1'b0;
        push_exp(1, "disabled", M_CNT | M_ERR | M_AN | M_SEG, 8'h00, 8'h00, 1'b0, 4'b0000, 7'b1111111);
        push_exp(3, "disabled_hold", M_CNT | M_AN | M_SEG, 8'h00, 8'h00, 1'b0, 4'b0000, 7'b1111111);
        step(3);
        en = 1'b1;
        exp_cnt(3, "reenable_no_load", 8'h00, 8'h00);
        step(3);
        tick_1s = 1'b0;
        set_vec(c_vec_r1y2);
        exp_cnt(1, "reenable_change", 8'h00, 8'h05);
        step(1);

        // Drain the scoreboard with a bounded wait.
        waited = 0;
        while (sb.size() > 0 && waited < 20) begin
            step(1);
            waited++;
        end
        while (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: expectation due at cyc %0d never checked", sb_name[0], sb[0].due);
            void'(sb.pop_front());
            void'(sb_name.pop_front());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
